// File: rtl/div_sched_rr_pkg.sv
// Shared types and constants for the round-robin divider scheduler.
package div_sched_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Response error codes
  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_DBZ = 2'b01,
    ERR_TMO = 2'b10
  } err_t;

  // Width of requester index / grant_o (covers NREQ up to 8)
  localparam int unsigned IDXW = 3;

  // Divide-by-zero quotient: all ones, sliced to XLEN (XLEN <= 64)
  localparam logic [63:0] DBZ_QUOT = '1;

endpackage

// File: rtl/div_sched_rr_if.sv
// Requester-side job/response channel bundle for div_sched_rr.
interface div_sched_rr_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 32
) ();

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*XLEN-1:0] req_dividend_i;
  logic [NREQ*XLEN-1:0] req_divisor_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  logic [XLEN-1:0]      rsp_quotient_o;
  logic [XLEN-1:0]      rsp_remainder_o;
  logic [1:0]           rsp_err_o;

  // Requester side
  modport master (
    output req_valid_i, req_dividend_i, req_divisor_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o, rsp_err_o
  );

  // Scheduler side
  modport slave (
    input  req_valid_i, req_dividend_i, req_divisor_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_quotient_o, rsp_remainder_o, rsp_err_o
  );

endinterface

// File: rtl/div_sched_rr_arb.sv
// Combinational round-robin picker: first asserted request at or above ptr, with wrap.
module rr_arbiter_nreq
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] idx,
  output logic            found
);

  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NREQ);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDXW-1:0]   off;
  logic [IDXW:0]     sum;

  // Rotate requests so ptr sits at bit 0, priority-encode, then rotate the index back
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = IDXW'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    idx = sum[IDXW-1:0];
    gnt = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (found && idx == IDXW'(i)) gnt[i] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sched_rr.sv
// Round-robin scheduler sharing one serial divider core among NREQ requesters.
module div_sched_rr
  import div_sched_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned XLEN = 32,
  parameter int unsigned TMO  = 40,
  parameter int unsigned TMOW = 6
) (
  input  logic            clk_i,
  input  logic            reset_i,
  div_sched_rr_if.slave   req_if,
  output logic            div_start_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  input  logic            div_fini_i,
  input  logic [XLEN-1:0] div_quotient_i,
  input  logic [XLEN-1:0] div_remainder_i,
  output logic            busy_o,
  output logic [2:0]      grant_o
);

  state_t          state_q, state_d;
  logic [IDXW-1:0] ptr_q, grant_q, next_ptr;
  logic [TMOW-1:0] tmo_q;
  logic [XLEN-1:0] quot_q, rem_q;
  err_t            err_q;

  logic [NREQ-1:0] arb_gnt, owner_oh;
  logic [IDXW-1:0] arb_idx;
  logic            arb_found;
  logic [XLEN-1:0] sel_dividend, sel_divisor;
  logic            accept, rsp_done, tmo_hit;

  rr_arbiter_nreq #(.NREQ(NREQ)) u_arb (
    .req   (req_if.req_valid_i),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .found (arb_found)
  );

  // Operand mux for the requester the arbiter picked
  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (arb_idx == IDXW'(k)) begin
        sel_dividend = req_if.req_dividend_i[k*XLEN +: XLEN];
        sel_divisor  = req_if.req_divisor_i[k*XLEN +: XLEN];
      end
    end
  end

  // One-hot decode of the current owner
  always_comb begin
    owner_oh = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_q == IDXW'(k)) owner_oh[k] = 1'b1;
    end
  end

  assign accept   = (state_q == ST_IDLE) && arb_found;
  assign rsp_done = |(req_if.rsp_ready_i & owner_oh);
  assign next_ptr = (arb_idx == IDXW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
  // WAIT cycle j after the start pulse sees tmo_q == j-1; aborting when
  // tmo_q == TMO-2 puts the timeout response exactly TMO cycles after start.
  assign tmo_hit  = (tmo_q == TMOW'(TMO-2));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = (sel_divisor == '0) ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (div_fini_i || tmo_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Job latch, core handshake and result capture
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q          <= '0;
      grant_q        <= '0;
      tmo_q          <= '0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      quot_q         <= '0;
      rem_q          <= '0;
      err_q          <= ERR_OK;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ptr_q          <= next_ptr;
            grant_q        <= arb_idx;
            div_dividend_o <= sel_dividend;
            div_divisor_o  <= sel_divisor;
            if (sel_divisor == '0) begin
              quot_q <= DBZ_QUOT[XLEN-1:0];
              rem_q  <= sel_dividend;
              err_q  <= ERR_DBZ;
            end
          end
        end
        ST_ISSUE: tmo_q <= '0;
        ST_WAIT: begin
          tmo_q <= tmo_q + 1'b1;
          if (div_fini_i) begin
            quot_q <= div_quotient_i;
            rem_q  <= div_remainder_i;
            err_q  <= ERR_OK;
          end else if (tmo_hit) begin
            quot_q <= '0;
            rem_q  <= '0;
            err_q  <= ERR_TMO;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_if.req_ready_o     = (state_q == ST_IDLE) ? arb_gnt : '0;
  assign req_if.rsp_valid_o     = (state_q == ST_RESP) ? owner_oh : '0;
  assign req_if.rsp_quotient_o  = quot_q;
  assign req_if.rsp_remainder_o = rem_q;
  assign req_if.rsp_err_o       = err_q;
  assign div_start_o            = (state_q == ST_ISSUE);
  assign busy_o                 = (state_q != ST_IDLE);
  assign grant_o                = grant_q;

endmodule

// File: tb/tb_div_sched_rr.sv
// Directed self-checking bench for div_sched_rr (NREQ=2, XLEN=32, TMO=40).
module tb_div_sched_rr;

  localparam int unsigned NREQ = 2;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 40;
  localparam int unsigned TMOW = 6;

  logic            clk = 1'b0;
  logic            reset_i;
  logic            div_start_o;
  logic [XLEN-1:0] div_dividend_o, div_divisor_o;
  logic            div_fini_i;
  logic [XLEN-1:0] div_quotient_i, div_remainder_i;
  logic            busy_o;
  logic [2:0]      grant_o;

  int n_tests = 0;
  int n_fail  = 0;
  int got;

  div_sched_rr_if #(.NREQ(NREQ), .XLEN(XLEN)) rif ();

  div_sched_rr #(.NREQ(NREQ), .XLEN(XLEN), .TMO(TMO), .TMOW(TMOW)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .req_if          (rif),
    .div_start_o     (div_start_o),
    .div_dividend_o  (div_dividend_o),
    .div_divisor_o   (div_divisor_o),
    .div_fini_i      (div_fini_i),
    .div_quotient_i  (div_quotient_i),
    .div_remainder_i (div_remainder_i),
    .busy_o          (busy_o),
    .grant_o         (grant_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned k, input logic [31:0] a, input logic [31:0] b);
    rif.req_dividend_i[k*XLEN +: XLEN] = a;
    rif.req_divisor_i[k*XLEN +: XLEN]  = b;
  endtask

  // Stand-in core: from ISSUE, enter WAIT, idle lat cycles, then pulse fini
  task automatic core_finish(input int unsigned lat, input logic [31:0] q, input logic [31:0] r);
    tick();
    repeat (lat) tick();
    div_fini_i      = 1'b1;
    div_quotient_i  = q;
    div_remainder_i = r;
    tick();
    div_fini_i      = 1'b0;
    div_quotient_i  = '0;
    div_remainder_i = '0;
  endtask

  task automatic ack(input logic [1:0] m);
    rif.rsp_ready_i = m;
    tick();
    rif.rsp_ready_i = '0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    reset_i             = 1'b1;
    rif.req_valid_i     = '0;
    rif.req_dividend_i  = '0;
    rif.req_divisor_i   = '0;
    rif.rsp_ready_i     = '0;
    div_fini_i          = 1'b0;
    div_quotient_i      = '0;
    div_remainder_i     = '0;
    repeat (2) tick();
    reset_i = 1'b0;

    // Reset state
    chk("rst_busy",   busy_o, 0);
    chk("rst_start",  div_start_o, 0);
    chk("rst_grant",  grant_o, 0);
    chk("rst_rspv",   rif.rsp_valid_o, 0);
    chk("rst_ready",  rif.req_ready_o, 0);
    chk("rst_quot",   rif.rsp_quotient_o, 0);
    chk("rst_rem",    rif.rsp_remainder_o, 0);
    chk("rst_err",    rif.rsp_err_o, 0);
    chk("rst_dvd",    div_dividend_o, 0);
    chk("rst_dvs",    div_divisor_o, 0);

    // Single job: req0 100/7
    set_req(0, 100, 7);
    rif.req_valid_i = 2'b01;
    #1;
    chk("single_ready", rif.req_ready_o, 2'b01);
    tick();
    rif.req_valid_i = 2'b00;
    chk("single_start", div_start_o, 1);
    chk("single_dvd",   div_dividend_o, 100);
    chk("single_dvs",   div_divisor_o, 7);
    chk("single_busy",  busy_o, 1);
    chk("single_rdy_issue", rif.req_ready_o, 0);
    tick();
    chk("single_start_once", div_start_o, 0);
    repeat (2) tick();
    div_fini_i = 1'b1; div_quotient_i = 14; div_remainder_i = 2;
    tick();
    div_fini_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
    chk("single_rspv",  rif.rsp_valid_o, 2'b01);
    chk("single_quot",  rif.rsp_quotient_o, 14);
    chk("single_rem",   rif.rsp_remainder_o, 2);
    chk("single_err",   rif.rsp_err_o, 0);
    chk("single_grant", grant_o, 0);
    ack(2'b01);
    chk("single_idle_busy", busy_o, 0);
    chk("single_idle_rspv", rif.rsp_valid_o, 0);

    // Contention from ptr=0: req0 first, then req1 50/5
    do_reset();
    set_req(0, 60, 4);
    set_req(1, 50, 5);
    rif.req_valid_i = 2'b11;
    #1;
    chk("cont_ready0", rif.req_ready_o, 2'b01);
    tick();
    rif.req_valid_i = 2'b10;
    chk("cont_grant0", grant_o, 0);
    chk("cont_dvs0",   div_divisor_o, 4);
    core_finish(2, 15, 0);
    chk("cont_rspv0",  rif.rsp_valid_o, 2'b01);
    chk("cont_quot0",  rif.rsp_quotient_o, 15);
    chk("cont_rdy_resp", rif.req_ready_o, 0);
    ack(2'b01);
    chk("cont_ready1", rif.req_ready_o, 2'b10);
    tick();
    rif.req_valid_i = 2'b00;
    chk("cont_grant1", grant_o, 1);
    chk("cont_dvs1",   div_divisor_o, 5);
    core_finish(2, 10, 0);
    chk("cont_rspv1",  rif.rsp_valid_o, 2'b10);
    chk("cont_quot1",  rif.rsp_quotient_o, 10);
    chk("cont_rem1",   rif.rsp_remainder_o, 0);
    ack(2'b10);

    // Back-to-back alternation with both requesters always valid
    set_req(0, 20, 3);
    set_req(1, 50, 5);
    rif.req_valid_i = 2'b11;
    #1;
    chk("alt_ready_j0", rif.req_ready_o, 2'b01);
    tick();
    chk("alt_grant_j0", grant_o, 0);
    core_finish(1, 6, 2);
    chk("alt_quot_j0", rif.rsp_quotient_o, 6);
    chk("alt_rspv_j0", rif.rsp_valid_o, 2'b01);
    ack(2'b11);
    chk("alt_ready_j1", rif.req_ready_o, 2'b10);
    tick();
    chk("alt_grant_j1", grant_o, 1);
    core_finish(1, 10, 0);
    chk("alt_quot_j1", rif.rsp_quotient_o, 10);
    chk("alt_rspv_j1", rif.rsp_valid_o, 2'b10);
    ack(2'b11);
    chk("alt_ready_j2", rif.req_ready_o, 2'b01);
    tick();
    chk("alt_grant_j2", grant_o, 0);
    core_finish(1, 6, 2);
    chk("alt_rem_j2", rif.rsp_remainder_o, 2);
    ack(2'b11);
    chk("alt_ready_j3", rif.req_ready_o, 2'b10);
    tick();
    chk("alt_grant_j3", grant_o, 1);
    core_finish(1, 10, 0);
    chk("alt_rspv_j3", rif.rsp_valid_o, 2'b10);
    ack(2'b11);
    rif.req_valid_i = 2'b00;

    // Divide-by-zero: req1 123/0
    set_req(1, 123, 0);
    rif.req_valid_i = 2'b10;
    #1;
    chk("dbz_ready", rif.req_ready_o, 2'b10);
    tick();
    rif.req_valid_i = 2'b00;
    chk("dbz_start", div_start_o, 0);
    chk("dbz_rspv",  rif.rsp_valid_o, 2'b10);
    chk("dbz_quot",  rif.rsp_quotient_o, 32'hFFFF_FFFF);
    chk("dbz_rem",   rif.rsp_remainder_o, 123);
    chk("dbz_err",   rif.rsp_err_o, 2'b01);
    chk("dbz_grant", grant_o, 1);
    ack(2'b10);
    chk("dbz_idle", busy_o, 0);

    // Timeout: core never finishes
    set_req(0, 1000, 10);
    rif.req_valid_i = 2'b01;
    tick();
    rif.req_valid_i = 2'b00;
    chk("tmo_start", div_start_o, 1);
    got = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (rif.rsp_valid_o != '0) begin
        got = c;
        break;
      end
    end
    chk("tmo_latency", got, TMO);
    chk("tmo_rspv", rif.rsp_valid_o, 2'b01);
    chk("tmo_quot", rif.rsp_quotient_o, 0);
    chk("tmo_rem",  rif.rsp_remainder_o, 0);
    chk("tmo_err",  rif.rsp_err_o, 2'b10);
    div_fini_i = 1'b1; div_quotient_i = 55; div_remainder_i = 66;
    tick();
    div_fini_i = 1'b0;
    chk("tmo_late_quot", rif.rsp_quotient_o, 0);
    chk("tmo_late_err",  rif.rsp_err_o, 2'b10);
    ack(2'b01);
    div_fini_i = 1'b1;
    tick();
    div_fini_i = 1'b0; div_quotient_i = '0; div_remainder_i = '0;
    chk("idle_fini_busy", busy_o, 0);
    chk("idle_fini_quot", rif.rsp_quotient_o, 0);

    // Backpressure on req1 while req0 also waits
    set_req(0, 9, 3);
    set_req(1, 50, 5);
    rif.req_valid_i = 2'b11;
    #1;
    chk("bp_ready", rif.req_ready_o, 2'b10);
    tick();
    rif.req_valid_i = 2'b01;
    core_finish(2, 10, 0);
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold_rspv", rif.rsp_valid_o, 2'b10);
      chk("bp_hold_quot", rif.rsp_quotient_o, 10);
      chk("bp_hold_rdy",  rif.req_ready_o, 0);
      tick();
    end
    ack(2'b10);
    chk("bp_rel_busy",  busy_o, 0);
    chk("bp_rel_rspv",  rif.rsp_valid_o, 0);
    chk("bp_rel_ready", rif.req_ready_o, 2'b01);
    tick();
    rif.req_valid_i = 2'b00;
    chk("bp_next_start", div_start_o, 1);
    chk("bp_next_grant", grant_o, 0);

    // Reset mid-WAIT, then a clean 9/3 job
    repeat (2) tick();
    do_reset();
    chk("mid_rst_busy",  busy_o, 0);
    chk("mid_rst_rspv",  rif.rsp_valid_o, 0);
    chk("mid_rst_start", div_start_o, 0);
    chk("mid_rst_grant", grant_o, 0);
    chk("mid_rst_dvd",   div_dividend_o, 0);
    chk("mid_rst_quot",  rif.rsp_quotient_o, 0);
    chk("mid_rst_err",   rif.rsp_err_o, 0);
    repeat (3) tick();
    chk("mid_rst_norsp", rif.rsp_valid_o, 0);
    rif.req_valid_i = 2'b01;
    #1;
    chk("post_rst_ready", rif.req_ready_o, 2'b01);
    tick();
    rif.req_valid_i = 2'b00;
    chk("post_rst_dvd", div_dividend_o, 9);
    core_finish(2, 3, 0);
    chk("post_rst_rspv", rif.rsp_valid_o, 2'b01);
    chk("post_rst_quot", rif.rsp_quotient_o, 3);
    chk("post_rst_rem",  rif.rsp_remainder_o, 0);
    chk("post_rst_err",  rif.rsp_err_o, 0);
    ack(2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sched_rr.md
Name: div_sched_rr

Overview:
- Round-robin scheduler that shares one serial divider core among NREQ requesters (e.g. Wishbone register front-end, LA port, future accelerators).
- Accepts divide jobs on per-requester valid/ready channels and sequences the core: operand load, start pulse, wait for finish.
- Returns quotient/remainder to the owning requester; handles divide-by-zero and hung-core timeout locally.
- Sits between the requesters and the divider core inside the serial-divider project.

Parameters:
- NREQ, 2, number of requesters (2..8).
- XLEN, 32, operand/result width.
- TMO, 40, max cycles from div_start_o to div_fini_i before abort (must be greater than XLEN+2).
- TMOW, 6, width of timeout counter (at least clog2(TMO+1)).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- req_valid_i  in  NREQ  per-requester job valid.
- req_ready_o  out  NREQ  one-hot job accept; job taken when valid&ready in the same cycle.
- req_dividend_i  in  NREQ*XLEN  packed dividends, requester k at [k*XLEN +: XLEN].
- req_divisor_i  in  NREQ*XLEN  packed divisors, same packing.
- rsp_valid_o  out  NREQ  one-hot response valid.
- rsp_ready_i  in  NREQ  per-requester response accept.
- rsp_quotient_o  out  XLEN  shared response quotient.
- rsp_remainder_o  out  XLEN  shared response remainder.
- rsp_err_o  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- div_start_o  out  1  one-cycle start pulse to core.
- div_dividend_o  out  XLEN  registered operand to core.
- div_divisor_o  out  XLEN  registered operand to core.
- div_fini_i  in  1  core done pulse; results valid that cycle.
- div_quotient_i  in  XLEN  core quotient.
- div_remainder_i  in  XLEN  core remainder.
- busy_o  out  1  high in any state but IDLE.
- grant_o  out  3  index of current owner.

Behaviour:
- Reset values:
  - all outputs 0.
  - FSM=IDLE, rr pointer=0, timeout counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Round-robin pick: first k with req_valid_i[k], searching from ptr upward with wrap.
  - Assert req_ready_o[k] combinationally; only in IDLE, only one-hot.
  - On handshake: latch operands, latch grant_o=k, set ptr=(k+1) mod NREQ.
  - Divisor==0: load rsp_quotient_o=all-ones, rsp_remainder_o=dividend, err=01, go to RESP (core never started).
  - Divisor nonzero: go to ISSUE.
- ISSUE:
  - div_start_o=1 for exactly this cycle; operands held stable.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - On div_fini_i: capture quotient/remainder, err=00, go to RESP.
  - Counter reaching TMO without fini: quotient=0, remainder=0, err=10, go to RESP.
  - fini and timeout in the same cycle: fini wins.
  - div_fini_i outside WAIT is ignored.
- RESP:
  - rsp_valid_o[grant] held with data stable until rsp_ready_i[grant].
  - Then clear rsp_valid_o, go to IDLE.
  - Next job accepted no earlier than the following cycle.
- Latency, nonzero divisor: accept(IDLE) → start 1 cycle later → result visible 1 cycle after fini.
- Latency, divisor==0: response 1 cycle after accept.
- Requests are not buffered. A requester must hold valid and operands until ready; dropping valid before ready is legal and simply withdraws the request.
- busy_o=1 in ISSUE/WAIT/RESP.
- reset_i asserted mid-operation:
  - Immediate return to reset state; in-flight job lost, no response.
  - Core must be reset by the same reset_i.
- Arithmetic: no width changes; outputs are exactly XLEN bits from core or constants.

Decomposition:
- Shared package div_sched_pkg:
  - FSM state encoding (2-bit).
  - rsp_err codes ERR_OK/ERR_DBZ/ERR_TMO.
  - DBZ quotient constant.
- One natural sub-module: rr_arbiter_nreq.
  - Combinational round-robin pick from ptr.
  - Outputs a one-hot grant and a binary index.
  - Reusable for other shared resources.

Test Plan:
- Single job: NREQ=2, req0 100/7 → one start pulse; rsp_valid_o=01 with quotient=14, remainder=2, err=00; grant_o=0.
- Contention: req0 and req1 both valid in IDLE with ptr=0 → req0 served first; req1 (50/5) next → quotient=10, remainder=0; ptr then 0. Repeat with three back-to-back jobs from both to confirm alternation 0,1,0,1.
- Divide-by-zero: req1 123/0 → no div_start_o; rsp_valid_o=10 one cycle after accept, quotient=FFFFFFFF, remainder=123, err=01.
- Timeout: core model never asserts fini → response TMO cycles after start with quotient=0, remainder=0, err=10; a fini arriving afterwards is ignored.
- Backpressure: hold rsp_ready_i=0 for 10 cycles → rsp data stable, req_ready_o=0 throughout; release → IDLE next cycle, next job accepted.
- Reset mid-WAIT: assert reset_i for 1 cycle → all outputs 0, busy_o=0, no rsp_valid_o; a subsequent job 9/3 completes normally (quotient=3, remainder=0).
